// File: rtl/rr_mux4_arbiter.sv
// Four-way round-robin arbiter with a registered output stage.
// It picks one valid requester per cycle and steers that requester's data
// through a 4:1 select into the output register. The result appears one cycle
// later, and the output can move one word per cycle.
module rr_mux4_arbiter #(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [3:0]     in_valid,
  input  logic [4*W-1:0] in_data,
  output logic [3:0]     in_ready,
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  output logic [1:0]     out_src,
  input  logic           out_ready
);

  logic [1:0]   ptr;
  logic         load_en;
  logic         win_found;
  logic [1:0]   win_idx;
  logic [W-1:0] sel_data;

  assign load_en = !out_valid || out_ready;

  // Find the first valid requester, scanning upward from ptr and wrapping at 3.
  always_comb begin
    logic [1:0] cand;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      cand = ptr + 2'(k);
      if (!win_found && in_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // 4:1 data select, using the same index encoding as out_src.
  always_comb begin
    sel_data = '0;
    case (win_idx)
      2'd0: sel_data = in_data[0*W +: W];
      2'd1: sel_data = in_data[1*W +: W];
      2'd2: sel_data = in_data[2*W +: W];
      2'd3: sel_data = in_data[3*W +: W];
      default: sel_data = '0;
    endcase
  end

  // One-hot grant to the winner. It is held low during reset and while the output stalls.
  always_comb begin
    in_ready = '0;
    if (rst_n && load_en && win_found) begin
      in_ready[win_idx] = 1'b1;
    end
  end

  // Output register and priority pointer. Both update only when the output can load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      ptr       <= '0;
    end else if (load_en) begin
      if (win_found) begin
        out_valid <= 1'b1;
        out_data  <= sel_data;
        out_src   <= win_idx;
        ptr       <= win_idx + 2'd1;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_mux4_arbiter.sv
// Directed testbench for rr_mux4_arbiter with W=4.
module tb_rr_mux4_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  in_valid;
  logic [15:0] in_data;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [3:0]  out_data;
  logic [1:0]  out_src;
  logic        out_ready;

  int total = 0;
  int bad   = 0;

  rr_mux4_arbiter #(.W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 4'b0000; out_ready = 1'b1;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 4'b1111; in_data = 16'hDCBA; out_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      total++;
      if (in_ready !== 4'b0000) begin bad++; $display("FAIL rst_ready cyc=%0d got=%b exp=0000", c, in_ready); end
      tick();
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid cyc=%0d got=%b exp=0", c, out_valid); end
      total++;
      if (out_data !== 4'h0) begin bad++; $display("FAIL rst_data cyc=%0d got=%h exp=0", c, out_data); end
      total++;
      if (out_src !== 2'd0) begin bad++; $display("FAIL rst_src cyc=%0d got=%0d exp=0", c, out_src); end
    end
    rst_n = 1'b1; in_valid = 4'b0000;
    for (int c = 0; c < 5; c++) begin
      #1;
      total++;
      if (in_ready !== 4'b0000) begin bad++; $display("FAIL idle_ready cyc=%0d got=%b exp=0000", c, in_ready); end
      tick();
      total++;
      if (out_valid !== 1'b0 || out_data !== 4'h0 || out_src !== 2'd0) begin
        bad++; $display("FAIL idle_out cyc=%0d got=%b/%h/%0d exp=0/0/0", c, out_valid, out_data, out_src);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] es;
    logic [3:0] er;
    logic [3:0] ed;
    do_reset();
    in_valid = 4'b1111; in_data = 16'hDCBA; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      es = 2'(i % 4);
      er = 4'b0001 << es;
      ed = 4'hA + 4'(es);
      #1;
      total++;
      if (in_ready !== er) begin bad++; $display("FAIL rr_ready i=%0d got=%b exp=%b", i, in_ready, er); end
      tick();
      total++;
      if (out_valid !== 1'b1) begin bad++; $display("FAIL rr_valid i=%0d got=%b exp=1", i, out_valid); end
      total++;
      if (out_src !== es) begin bad++; $display("FAIL rr_src i=%0d got=%0d exp=%0d", i, out_src, es); end
      total++;
      if (out_data !== ed) begin bad++; $display("FAIL rr_data i=%0d got=%h exp=%h", i, out_data, ed); end
    end
    in_valid = 4'b0000;
    tick();
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL rr_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_backpressure();
    do_reset();
    in_valid = 4'b0110; in_data = 16'h0750; out_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 4'b0010) begin bad++; $display("FAIL bp_first_ready got=%b exp=0010", in_ready); end
    tick();
    total++;
    if (out_valid !== 1'b1 || out_src !== 2'd1 || out_data !== 4'h5) begin
      bad++; $display("FAIL bp_first_out got=%b/%0d/%h exp=1/1/5", out_valid, out_src, out_data);
    end
    out_ready = 1'b0;
    in_data = 16'h0790;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++;
      if (in_ready !== 4'b0000) begin bad++; $display("FAIL bp_stall_ready cyc=%0d got=%b exp=0000", c, in_ready); end
      tick();
      total++;
      if (out_valid !== 1'b1 || out_src !== 2'd1 || out_data !== 4'h5) begin
        bad++; $display("FAIL bp_hold cyc=%0d got=%b/%0d/%h exp=1/1/5", c, out_valid, out_src, out_data);
      end
    end
    out_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 4'b0100) begin bad++; $display("FAIL bp_resume_ready got=%b exp=0100", in_ready); end
    tick();
    total++;
    if (out_valid !== 1'b1 || out_src !== 2'd2 || out_data !== 4'h7) begin
      bad++; $display("FAIL bp_resume_out got=%b/%0d/%h exp=1/2/7", out_valid, out_src, out_data);
    end
    in_valid = 4'b0000;
    tick();
  endtask

  task automatic test_wrap();
    do_reset();
    in_valid = 4'b1000; in_data = 16'h3001; out_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 4'b1000) begin bad++; $display("FAIL wrap_ready3 got=%b exp=1000", in_ready); end
    tick();
    total++;
    if (out_src !== 2'd3 || out_data !== 4'h3) begin bad++; $display("FAIL wrap_out3 got=%0d/%h exp=3/3", out_src, out_data); end
    in_valid = 4'b1001;
    #1;
    total++;
    if (in_ready !== 4'b0001) begin bad++; $display("FAIL wrap_ready0 got=%b exp=0001", in_ready); end
    tick();
    total++;
    if (out_src !== 2'd0 || out_data !== 4'h1) begin bad++; $display("FAIL wrap_out0 got=%0d/%h exp=0/1", out_src, out_data); end
    #1;
    total++;
    if (in_ready !== 4'b1000) begin bad++; $display("FAIL wrap_ready3b got=%b exp=1000", in_ready); end
    tick();
    total++;
    if (out_src !== 2'd3 || out_data !== 4'h3) begin bad++; $display("FAIL wrap_out3b got=%0d/%h exp=3/3", out_src, out_data); end
    in_valid = 4'b0000;
    tick();
  endtask

  task automatic test_sparse();
    logic ev;
    do_reset();
    in_data = 16'h0600; out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      ev = (k % 2 == 0);
      in_valid = ev ? 4'b0100 : 4'b0000;
      #1;
      total++;
      if (in_ready !== (ev ? 4'b0100 : 4'b0000)) begin bad++; $display("FAIL sp_ready k=%0d got=%b exp=%b", k, in_ready, ev ? 4'b0100 : 4'b0000); end
      tick();
      total++;
      if (out_valid !== ev || out_src !== 2'd2 || out_data !== 4'h6) begin
        bad++; $display("FAIL sp_out k=%0d got=%b/%0d/%h exp=%b/2/6", k, out_valid, out_src, out_data, ev);
      end
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    in_valid = 4'b0010; in_data = 16'h4350; out_ready = 1'b1;
    tick();
    total++;
    if (out_valid !== 1'b1 || out_src !== 2'd1) begin bad++; $display("FAIL mr_pre got=%b/%0d exp=1/1", out_valid, out_src); end
    out_ready = 1'b0; rst_n = 1'b0; in_valid = 4'b1111;
    #1;
    total++;
    if (in_ready !== 4'b0000) begin bad++; $display("FAIL mr_ready got=%b exp=0000", in_ready); end
    tick();
    total++;
    if (out_valid !== 1'b0 || out_src !== 2'd0 || out_data !== 4'h0) begin
      bad++; $display("FAIL mr_out got=%b/%0d/%h exp=0/0/0", out_valid, out_src, out_data);
    end
    rst_n = 1'b1; out_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 4'b0001) begin bad++; $display("FAIL mr_restart_ready got=%b exp=0001", in_ready); end
    tick();
    total++;
    if (out_valid !== 1'b1 || out_src !== 2'd0 || out_data !== 4'h0) begin
      bad++; $display("FAIL mr_restart_out got=%b/%0d/%h exp=1/0/0", out_valid, out_src, out_data);
    end
    in_valid = 4'b0000;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 4'b0000; in_data = '0; out_ready = 1'b1;
    tick();
    test_reset();
    test_round_robin();
    test_backpressure();
    test_wrap();
    test_sparse();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_mux4_arbiter.md
Name: rr_mux4_arbiter

Overview:
- Round-robin arbiter that shares one output channel between four valid/ready requesters.
- Each cycle it chooses one requester and steers that requester's data through a 4:1 select (sel[1:0] encoding, d0..d3 order) into a registered output stage.
- Sits in front of any single-consumer resource that four producers must share.
- Provides fair access, 1-cycle latency and full throughput (one transfer per cycle).

Parameters:
- W, 4, data width of each requester and of the output.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous reset, active-low; sampled on rising clk.
- in_valid  input  4  bit i = requester i has data.
- in_data  input  4*W  requester i data in bits [i*W +: W].
- in_ready  output  4  bit i = requester i's data is taken this cycle; combinational.
- out_valid  output  1  output register holds data; registered.
- out_data  output  W  selected data; registered.
- out_src  output  2  index of requester that produced out_data; registered; same encoding as mux sel.
- out_ready  input  1  consumer accepts out_data this cycle.

Behaviour:
- Reset (rst_n=0 at clk edge):
  - out_valid=0, out_data=0, out_src=0, priority pointer ptr=0.
  - in_ready is forced to 0 during the reset cycle.
- load_en = !out_valid || out_ready. Output register may load whenever it is empty or is being drained this cycle.
- Arbitration (combinational):
  - Scan requesters in order ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - Winner = first with in_valid=1.
  - If no in_valid bit is set, there is no winner.
- in_ready[i] = rst_n && load_en && (i == winner). At most one bit is high. in_ready may depend on in_valid; producers must not make in_valid depend on in_ready.
- On a clk edge with rst_n=1:
  - Load with winner: out_valid<=1, out_data<=in_data[winner], out_src<=winner, ptr<=(winner+1) mod 4.
  - load_en with no winner: out_valid<=0; out_data, out_src and ptr hold.
  - !load_en (out_valid=1, out_ready=0): out_valid, out_data, out_src and ptr hold; all in_ready=0.
- Latency: data accepted at edge N appears on out_* immediately after edge N.
- Throughput: with out_ready held at 1, one transfer every cycle.
- Simultaneous drain and load (out_valid=1, out_ready=1, winner present): the old word is consumed and the new word loads in the same edge, with no bubble.
- Fairness: the pointer advances past the winner only on acceptance. Any continuously-asserted requester is granted within 4 transfers.
- Pointer wrap: winner=3 sets ptr=0.
- Stability: while out_valid=1 and out_ready=0, out_data and out_src stay stable until accepted.
- Reset mid-operation: a pending output word is discarded (out_valid=0); no in_ready is issued that cycle.
- in_valid bits for requesters that are not granted are ignored; their data is not sampled.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, then in_valid=0000 and out_ready=1 for 5 cycles -> out_valid=0, out_data=0, out_src=0 and in_ready=0000 throughout.
- All four requesting, out_ready=1, data i = 4'hA+i with W=4:
  - Transfers out_src 0,1,2,3,0,... one per cycle.
  - out_data A,B,C,D,A.
  - in_ready one-hot 0001,0010,0100,1000,0001.
- Backpressure: requesters 1 and 2 valid, first grant to 1 (ptr=0), then out_ready=0 for 3 cycles -> out_valid=1, out_src=1 and out_data held for 3 cycles, in_ready=0000; on out_ready=1, the same edge consumes the word from 1 and loads from 2 with no bubble.
- Fairness/wrap: only requester 3 valid, one transfer (ptr becomes 0), then requesters 0 and 3 valid -> grant 0 first, then 3.
- Sparse/empty: single requester 2 valid every other cycle, out_ready=1 -> out_valid toggles 0/1 with 1-cycle latency, out_src=2; after the last transfer, out_valid=0 and out_data keeps the last value.
- Reset mid-transfer: out_valid=1, out_ready=0, assert rst_n=0 for 1 cycle -> out_valid=0, out_src=0, in_ready=0000 that cycle; after release, arbitration restarts with priority at requester 0.
